// File: rtl/instr_encoder_loader.sv
// Packs instruction commands into 32-bit MIPS words and streams them into
// instruction memory at sequential word addresses, one load session per start.
module instr_encoder_loader #(
    parameter int              ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_kind_i,
    input  logic [4:0]        cmd_rs_i,
    input  logic [4:0]        cmd_rt_i,
    input  logic [4:0]        cmd_rd_i,
    input  logic [5:0]        cmd_funct_i,
    input  logic [15:0]       cmd_imm_i,
    input  logic [25:0]       cmd_target_i,
    input  logic              cmd_last_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    input  logic              imem_ack_i,
    output logic              done_o,
    output logic              full_o,
    output logic [ADDR_W:0]   count_o
);
    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_e            state_q;
    logic              ready_q, we_q, done_q, full_q, last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              end_d;
    logic [31:0]       word_d;

    // Opcodes match exactly what the control decoder recognises.
    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs, rt, rd,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [5:0] op;
        case (kind)
            3'd1:    op = 6'b100011;
            3'd2:    op = 6'b101011;
            3'd3:    op = 6'b000100;
            3'd5:    op = 6'b001000;
            3'd6:    op = 6'b000110;
            3'd7:    op = 6'b000101;
            default: op = 6'b000000;
        endcase
        if (kind == 3'd0)      return {6'b000000, rs, rt, rd, 5'b00000, funct};
        else if (kind == 3'd4) return {6'b000010, target};
        else                   return {op, rs, rt, imm};
    endfunction

    assign word_d = encode(cmd_kind_i, cmd_rs_i, cmd_rt_i, cmd_rd_i,
                           cmd_funct_i, cmd_imm_i, cmd_target_i);
    // Session ends on a tagged last command or when the top address is written.
    assign end_d  = last_q | (addr_q == LAST_ADDR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= START_ADDR;
            wdata_q <= '0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q <= ACCEPT;
                        ready_q <= 1'b1;
                        addr_q  <= START_ADDR;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        full_q  <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (cmd_valid_i) begin
                        state_q <= WRITE;
                        ready_q <= 1'b0;
                        we_q    <= 1'b1;
                        wdata_q <= word_d;
                        last_q  <= cmd_last_i;
                    end
                end
                WRITE: begin
                    if (imem_ack_i) begin
                        we_q    <= 1'b0;
                        count_q <= count_q + CNT_ONE;
                        if (end_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            full_q  <= (addr_q == LAST_ADDR) & ~last_q;
                        end else begin
                            state_q <= ACCEPT;
                            ready_q <= 1'b1;
                            addr_q  <= addr_q + ADDR_ONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign done_o       = done_q;
    assign full_o       = full_q;
    assign count_o      = count_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed scoreboard bench: a default-size loader and a 4-word loader
// share command fields; sel routes handshakes and observation to one of them.
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        start = 1'b0, valid = 1'b0, ack = 1'b0;
    logic [2:0]  kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        last = 1'b0;

    logic        b_ready, b_we, b_done, b_full;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic [8:0]  b_count;
    logic        s_ready, s_we, s_done, s_full;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    instr_encoder_loader #(.ADDR_W(8)) u_big (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start & ~sel),
        .cmd_valid_i(valid & ~sel), .cmd_ready_o(b_ready),
        .cmd_kind_i(kind), .cmd_rs_i(rs), .cmd_rt_i(rt), .cmd_rd_i(rd),
        .cmd_funct_i(funct), .cmd_imm_i(imm), .cmd_target_i(target), .cmd_last_i(last),
        .imem_we_o(b_we), .imem_addr_o(b_addr), .imem_wdata_o(b_wdata),
        .imem_ack_i(ack & ~sel), .done_o(b_done), .full_o(b_full), .count_o(b_count));

    instr_encoder_loader #(.ADDR_W(2)) u_small (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start & sel),
        .cmd_valid_i(valid & sel), .cmd_ready_o(s_ready),
        .cmd_kind_i(kind), .cmd_rs_i(rs), .cmd_rt_i(rt), .cmd_rd_i(rd),
        .cmd_funct_i(funct), .cmd_imm_i(imm), .cmd_target_i(target), .cmd_last_i(last),
        .imem_we_o(s_we), .imem_addr_o(s_addr), .imem_wdata_o(s_wdata),
        .imem_ack_i(ack & sel), .done_o(s_done), .full_o(s_full), .count_o(s_count));

    logic        ready_v, we_v, done_v, full_v;
    logic [7:0]  addr_v;
    logic [31:0] wdata_v;
    logic [8:0]  count_v;
    assign ready_v = sel ? s_ready : b_ready;
    assign we_v    = sel ? s_we    : b_we;
    assign done_v  = sel ? s_done  : b_done;
    assign full_v  = sel ? s_full  : b_full;
    assign addr_v  = sel ? {6'd0, s_addr}  : b_addr;
    assign wdata_v = sel ? s_wdata : b_wdata;
    assign count_v = sel ? {6'd0, s_count} : b_count;

    typedef struct { logic [7:0] addr; logic [31:0] data; } exp_t;
    exp_t exp_q[$];
    logic [7:0] exp_addr = '0;
    int n_pass = 0, n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
        exp_addr = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, ready_v, 0);
        chk({tag, "_we"},    we_v,    0);
        chk({tag, "_addr"},  addr_v,  0);
        chk({tag, "_wdata"}, wdata_v, 0);
        chk({tag, "_done"},  done_v,  0);
        chk({tag, "_full"},  full_v,  0);
        chk({tag, "_count"}, count_v, 0);
    endtask

    task automatic send(input string tag, input logic [2:0] k, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [5:0] f, input logic [15:0] im,
                        input logic [25:0] tg, input logic lst, input logic [31:0] word,
                        input int ack_wait, input logic [7:0] max_addr);
        exp_t e;
        int n;
        kind = k; rs = a; rt = b; rd = c; funct = f; imm = im; target = tg; last = lst;
        exp_q.push_back('{addr: exp_addr, data: word});
        n = 0;
        while (!ready_v && n < 20) begin tick(); n++; end
        chk({tag, "_ready"}, ready_v, 1);
        valid = 1'b1; tick(); valid = 1'b0;
        chk({tag, "_we_lat1"}, we_v, 1);
        e = exp_q.pop_front();
        chk({tag, "_addr"},  addr_v,  e.addr);
        chk({tag, "_wdata"}, wdata_v, e.data);
        for (int i = 0; i < ack_wait; i++) begin
            tick();
            chk({tag, "_hold_we"},    we_v,    1);
            chk({tag, "_hold_addr"},  addr_v,  e.addr);
            chk({tag, "_hold_wdata"}, wdata_v, e.data);
            chk({tag, "_hold_ready"}, ready_v, 0);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        chk({tag, "_we_drop"}, we_v, 0);
        if (!lst && exp_addr != max_addr) exp_addr++;
    endtask

    initial begin
        repeat (3) tick();
        check_idle_outputs("rst");
        rst_n = 1'b1;
        tick();

        // R-format, single-word session
        pulse_start();
        send("t1_r", 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'h0, 1'b1, 32'h00221820, 0, 8'hFF);
        chk("t1_done", done_v, 1);
        chk("t1_count", count_v, 1);

        // cmd_valid while DONE is not consumed
        valid = 1'b1; tick(); tick();
        chk("done_ready", ready_v, 0);
        chk("done_we", we_v, 0);
        chk("done_count", count_v, 1);
        valid = 1'b0;

        pulse_start();
        chk("t2_restart_done", done_v, 0);
        chk("t2_restart_count", count_v, 0);
        send("t2_lw", 3'd1, 5'd16, 5'd8, 5'd0, 6'h00, 16'h0004, 26'h0, 1'b0, 32'h8E080004, 0, 8'hFF);
        // ack with no write pending is ignored
        ack = 1'b1; tick(); ack = 1'b0;
        chk("stray_ack_count", count_v, 1);
        chk("stray_ack_addr", addr_v, 1);
        send("t2_sw", 3'd2, 5'd16, 5'd8, 5'd0, 6'h00, 16'h0008, 26'h0, 1'b1, 32'hAE080008, 0, 8'hFF);
        chk("t2_count", count_v, 2);
        chk("t2_done", done_v, 1);

        pulse_start();
        send("t3_beq", 3'd3, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFF, 26'h0, 1'b0, 32'h1022FFFF, 0, 8'hFF);
        send("t3_j", 3'd4, 5'd7, 5'd7, 5'd7, 6'h3F, 16'h1234, 26'h0000100, 1'b1, 32'h08000100, 0, 8'hFF);
        chk("t3_done", done_v, 1);
        chk("t3_full", full_v, 0);
        chk("t3_count", count_v, 2);

        // memory stalls three cycles
        pulse_start();
        send("t4_addi", 3'd5, 5'd4, 5'd5, 5'd0, 6'h00, 16'h8001, 26'h0, 1'b1, 32'h20858001, 3, 8'hFF);
        chk("t4_count", count_v, 1);
        chk("t4_done", done_v, 1);

        // 4-word memory fills up
        sel = 1'b1;
        tick();
        pulse_start();
        send("t5_0", 3'd5, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005, 26'h0, 1'b0, 32'h20220005, 0, 8'd3);
        send("t5_1", 3'd6, 5'd3, 5'd4, 5'd0, 6'h00, 16'h0010, 26'h0, 1'b0, 32'h18640010, 0, 8'd3);
        send("t5_2", 3'd7, 5'd5, 5'd6, 5'd0, 6'h00, 16'hABCD, 26'h0, 1'b0, 32'h14A6ABCD, 1, 8'd3);
        send("t5_3", 3'd0, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h03FFF83F, 0, 8'd3);
        chk("t5_done", done_v, 1);
        chk("t5_full", full_v, 1);
        chk("t5_count", count_v, 4);
        chk("t5_addr", addr_v, 3);
        valid = 1'b1; tick();
        chk("t5_no_ready", ready_v, 0);
        tick();
        chk("t5_no_we", we_v, 0);
        valid = 1'b0;
        sel = 1'b0;
        tick();

        // reset in the middle of a write
        pulse_start();
        send("t6_pre", 3'd1, 5'd2, 5'd3, 5'd0, 6'h00, 16'h0001, 26'h0, 1'b0, 32'h8C430001, 0, 8'hFF);
        kind = 3'd2; last = 1'b0;
        valid = 1'b1; tick(); valid = 1'b0;
        chk("t6_in_write", we_v, 1);
        chk("t6_in_write_addr", addr_v, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        send("t6_again", 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'h0, 1'b1, 32'h00221820, 0, 8'hFF);
        chk("t6_count", count_v, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
